mid_sum_reducer: RTL and testbench

//  Consumer end of the parallel pairwise-sum stage: accepts a packed bus of LANES 2-bit partial sums
//  (lane k = bit[k+2]+bit[k] of a 32-bit register word) via valid/ready; reduces to one total in a
//  3-stage pipelined adder tree; presents it with valid/ready. Also keeps a saturating running total
//  and a count of delivered results, for the MipsBtbParallel datapath.

---
 rtl/mid_sum_reducer_pkg.sv | 23 ++
 rtl/mid_sum_reducer_if.sv | 25 ++
 rtl/mid_sum_reducer_stage.sv | 47 ++++
 rtl/mid_sum_reducer.sv | 110 +++++++++++
 tb/tb_mid_sum_reducer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mid_sum_reducer_pkg.sv
// Shared constants and sizing helpers for the pairwise-sum reduction pipeline.
package mid_sum_reducer_pkg;

    localparam int LANES_DEF  = 30;
    localparam int LANE_W_DEF = 2;
    localparam int ACC_W_DEF  = 16;
    localparam int GROUP_SIZE = 4;

    // Low bit of 1-based lane k inside the packed partial-sum bus.
    function automatic int lane_lo(input int k, input int lane_w);
        return (k - 32'sd1) * lane_w;
    endfunction

    function automatic int num_groups(input int lanes);
        return (lanes + GROUP_SIZE - 32'sd1) / GROUP_SIZE;
    endfunction

    // Total width must hold LANES copies of the largest lane value.
    function automatic int sum_width(input int lanes, input int lane_w);
        return $clog2(lanes * ((32'sd1 << lane_w) - 32'sd1) + 32'sd1);
    endfunction

endpackage

// File: rtl/mid_sum_reducer_if.sv
// Input and output valid/ready streams of the reducer, bundled for the top-level port list.
interface mid_sum_reducer_if
    import mid_sum_reducer_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int SUM_W  = sum_width(LANES_DEF, LANE_W_DEF)
);
    logic [LANES*LANE_W-1:0] partial_sums;
    logic                    in_valid;
    logic                    in_ready;
    logic [SUM_W-1:0]        sum;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output partial_sums, in_valid, out_ready,
        input  in_ready, sum, out_valid
    );

    modport slave (
        input  partial_sums, in_valid, out_ready,
        output in_ready, sum, out_valid
    );
endinterface

// File: rtl/mid_sum_reducer_stage.sv
// One pipeline stage: GROUPS parallel N-input adders sharing a single valid bit and enable.
module mid_sum_stage #(
    parameter int GROUPS = 1,
    parameter int N      = 4,
    parameter int IN_W   = 2,
    parameter int OUT_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_i,
    input  logic                     valid_i,
    input  logic [GROUPS*N*IN_W-1:0] data_i,
    output logic                     valid_o,
    output logic [GROUPS*OUT_W-1:0]  sum_o
);
    logic                    valid_q;
    logic [GROUPS*OUT_W-1:0] sum_q;
    logic [GROUPS*OUT_W-1:0] sum_d;

    // Per-group sum of N operands, zero-extended to the output width
    always_comb begin
        sum_d = '0;
        for (int g = 0; g < GROUPS; g++) begin
            for (int i = 0; i < N; i++) begin
                sum_d[g*OUT_W +: OUT_W] = sum_d[g*OUT_W +: OUT_W]
                                        + OUT_W'(data_i[(g*N + i)*IN_W +: IN_W]);
            end
        end
    end

    // Stage register: loads on enable, holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            sum_q   <= sum_d;
        end else begin
            valid_q <= valid_q;
            sum_q   <= sum_q;
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
endmodule

// File: rtl/mid_sum_reducer.sv
// Three-stage adder-tree reduction of packed lane sums, plus saturating delivered-total accumulator and counter.
module mid_sum_reducer
    import mid_sum_reducer_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int SUM_W  = sum_width(LANES_DEF, LANE_W_DEF),
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mid_sum_reducer_if.slave bus,
    input  logic             acc_clear,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] result_count
);
    localparam int NG  = num_groups(LANES);
    localparam int NP  = (NG + 1) / 2;
    localparam int G_W = LANE_W + 2;
    localparam int P_W = G_W + 1;

    logic                           advance_s;
    logic [NG*GROUP_SIZE*LANE_W-1:0] lanes_pad_s;
    logic [NG*G_W-1:0]              group_sum_s;
    logic [NP*2*G_W-1:0]            group_pad_s;
    logic [NP*P_W-1:0]              pair_sum_s;
    logic                           s1_valid_s;
    logic                           s2_valid_s;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] cnt_q;
    logic [ACC_W-1:0] cnt_d;
    logic [ACC_W:0]   acc_sum_s;
    logic             deliver_s;

    // A stalled output beat freezes the whole tree; bubbles travel like data.
    assign advance_s    = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance_s;

    // Missing lanes of the last group and the odd group of the last pair read as zero
    always_comb begin
        lanes_pad_s = '0;
        lanes_pad_s[LANES*LANE_W-1:0] = bus.partial_sums;
        group_pad_s = '0;
        group_pad_s[NG*G_W-1:0] = group_sum_s;
    end

    mid_sum_stage #(.GROUPS(NG), .N(GROUP_SIZE), .IN_W(LANE_W), .OUT_W(G_W)) u_stage1 (
        .clk     (clk),
        .reset   (reset),
        .en_i    (advance_s),
        .valid_i (bus.in_valid),
        .data_i  (lanes_pad_s),
        .valid_o (s1_valid_s),
        .sum_o   (group_sum_s)
    );

    mid_sum_stage #(.GROUPS(NP), .N(2), .IN_W(G_W), .OUT_W(P_W)) u_stage2 (
        .clk     (clk),
        .reset   (reset),
        .en_i    (advance_s),
        .valid_i (s1_valid_s),
        .data_i  (group_pad_s),
        .valid_o (s2_valid_s),
        .sum_o   (pair_sum_s)
    );

    mid_sum_stage #(.GROUPS(1), .N(NP), .IN_W(P_W), .OUT_W(SUM_W)) u_stage3 (
        .clk     (clk),
        .reset   (reset),
        .en_i    (advance_s),
        .valid_i (s2_valid_s),
        .data_i  (pair_sum_s),
        .valid_o (bus.out_valid),
        .sum_o   (bus.sum)
    );

    // Accumulator/counter next state; a clear beats a same-cycle delivery
    always_comb begin
        deliver_s = bus.out_valid && bus.out_ready;
        acc_sum_s = {1'b0, acc_q} + (ACC_W+1)'(bus.sum);
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        if (acc_clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (deliver_s) begin
            acc_d = acc_sum_s[ACC_W] ? {ACC_W{1'b1}} : acc_sum_s[ACC_W-1:0];
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + {{(ACC_W-1){1'b0}}, 1'b1};
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Accumulator/counter state register
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc          = acc_q;
    assign result_count = cnt_q;
endmodule

// File: tb/tb_mid_sum_reducer.sv
// Randomized and directed bench for mid_sum_reducer against a cycle-level behavioural reference model.
module tb_mid_sum_reducer;
    localparam int LANES = 30;
    localparam int PW    = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_r     = 1'b1;
    logic          in_valid_r  = 1'b0;
    logic          out_ready_r = 1'b1;
    logic          acc_clear_r = 1'b0;
    logic [PW-1:0] partial_r   = '0;

    logic [15:0] acc16, cnt16;
    logic [7:0]  acc8, cnt8;

    mid_sum_reducer_if #(.LANES(30), .LANE_W(2), .SUM_W(7)) bus16 ();
    mid_sum_reducer_if #(.LANES(30), .LANE_W(2), .SUM_W(7)) bus8 ();

    assign bus16.partial_sums = partial_r;
    assign bus16.in_valid     = in_valid_r;
    assign bus16.out_ready    = out_ready_r;
    assign bus8.partial_sums  = partial_r;
    assign bus8.in_valid      = in_valid_r;
    assign bus8.out_ready     = out_ready_r;

    mid_sum_reducer #(.LANES(30), .LANE_W(2), .SUM_W(7), .ACC_W(16)) dut (
        .clk(clk), .reset(reset_r), .bus(bus16), .acc_clear(acc_clear_r),
        .acc(acc16), .result_count(cnt16)
    );

    mid_sum_reducer #(.LANES(30), .LANE_W(2), .SUM_W(7), .ACC_W(8)) dut8 (
        .clk(clk), .reset(reset_r), .bus(bus8), .acc_clear(acc_clear_r),
        .acc(acc8), .result_count(cnt8)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    // Reference model: three-slot pipe (slot 2 is the output) and saturating totals
    bit mv[3];
    int ms[3];
    int macc16 = 0, mcnt16 = 0, macc8 = 0, mcnt8 = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int lane_total(input logic [PW-1:0] p);
        int t = 0;
        for (int k = 1; k <= LANES; k++) t += int'(p[2*k-1 -: 2]);
        return t;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // One clock: compare on the falling edge, advance the model on the rising edge
    task automatic step();
        bit adv, dlv;
        @(negedge clk);
        if (chk_en) begin
            check_eq("in_ready16", bus16.in_ready, !mv[2] || out_ready_r);
            check_eq("in_ready8", bus8.in_ready, !mv[2] || out_ready_r);
            check_eq("out_valid16", bus16.out_valid, mv[2]);
            check_eq("out_valid8", bus8.out_valid, mv[2]);
            if (mv[2]) begin
                check_eq("sum16", bus16.sum, ms[2]);
                check_eq("sum8", bus8.sum, ms[2]);
            end
            check_eq("acc16", acc16, macc16);
            check_eq("cnt16", cnt16, mcnt16);
            check_eq("acc8", acc8, macc8);
            check_eq("cnt8", cnt8, mcnt8);
        end
        @(posedge clk);
        cyc++;
        if (reset_r) begin
            for (int i = 0; i < 3; i++) begin mv[i] = 1'b0; ms[i] = 0; end
            macc16 = 0; mcnt16 = 0; macc8 = 0; mcnt8 = 0;
        end else begin
            adv = !mv[2] || out_ready_r;
            dlv = mv[2] && out_ready_r;
            if (acc_clear_r) begin
                macc16 = 0; mcnt16 = 0; macc8 = 0; mcnt8 = 0;
            end else if (dlv) begin
                macc16 = sat(macc16 + ms[2], 65535);
                mcnt16 = sat(mcnt16 + 1, 65535);
                macc8  = sat(macc8 + ms[2], 255);
                mcnt8  = sat(mcnt8 + 1, 255);
            end
            if (adv) begin
                mv[2] = mv[1]; ms[2] = ms[1];
                mv[1] = mv[0]; ms[1] = ms[0];
                mv[0] = in_valid_r; ms[0] = lane_total(partial_r);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_r = 1'b1; in_valid_r = 1'b0; out_ready_r = 1'b1; acc_clear_r = 1'b0;
        step();
        reset_r = 1'b0;
    endtask

    // Send n identical beats back to back, then let the pipe empty
    task automatic send_and_drain(input logic [PW-1:0] p, input int n);
        out_ready_r = 1'b1;
        partial_r   = p;
        for (int i = 0; i < n; i++) begin in_valid_r = 1'b1; step(); end
        in_valid_r = 1'b0;
        for (int i = 0; i < 5; i++) step();
    endtask

    logic [1:0]    pat2;
    logic [PW-1:0] p_all10, p_ten;
    int            got_sum[$], got_cyc[$], exp_q[$];
    int            start_cyc, n_sent, guard;
    logic [1:0]    pats[4];

    initial begin
        for (int i = 0; i < 3; i++) begin mv[i] = 1'b0; ms[i] = 0; end
        pat2 = 2'b10; p_all10 = {30{pat2}};
        pat2 = 2'b01; p_ten = '0; p_ten[19:0] = {10{pat2}};

        // Initial reset: DUT state is unknown until the first reset edge
        do_reset();
        chk_en = 1'b1;
        check_eq("rst_out_valid", bus16.out_valid, 1'b0);
        check_eq("rst_sum", bus16.sum, 7'd0);
        check_eq("rst_acc", acc16, 16'd0);
        check_eq("rst_cnt", cnt16, 16'd0);
        check_eq("rst_in_ready", bus16.in_ready, 1'b1);

        // Single beat of all 2'b10: total 60 appears 3 edges after acceptance
        got_sum = {}; got_cyc = {};
        start_cyc = cyc; partial_r = p_all10; in_valid_r = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            in_valid_r = 1'b0;
            if (bus16.out_valid) begin got_sum.push_back(int'(bus16.sum)); got_cyc.push_back(cyc - start_cyc); end
        end
        check_eq("t1_beats", got_sum.size(), 1);
        if (got_sum.size() == 1) begin
            check_eq("t1_sum", got_sum[0], 60);
            check_eq("t1_latency", got_cyc[0], 3);
        end

        // Four back-to-back uniform beats -> 30, 0, 60, 90 on consecutive cycles
        pats[0] = 2'b01; pats[1] = 2'b00; pats[2] = 2'b10; pats[3] = 2'b11;
        got_sum = {}; got_cyc = {}; start_cyc = cyc;
        for (int i = 0; i < 9; i++) begin
            if (i < 4) begin in_valid_r = 1'b1; pat2 = pats[i]; partial_r = {30{pat2}}; end
            else in_valid_r = 1'b0;
            step();
            if (bus16.out_valid) begin got_sum.push_back(int'(bus16.sum)); got_cyc.push_back(cyc - start_cyc); end
        end
        check_eq("t2_beats", got_sum.size(), 4);
        if (got_sum.size() == 4) begin
            check_eq("t2_sum0", got_sum[0], 30);
            check_eq("t2_sum1", got_sum[1], 0);
            check_eq("t2_sum2", got_sum[2], 60);
            check_eq("t2_sum3", got_sum[3], 90);
            check_eq("t2_first", got_cyc[0], 3);
            check_eq("t2_last", got_cyc[3], 6);
        end

        // Five-beat stream with a 4-cycle downstream stall in the middle
        do_reset();
        exp_q = {}; got_sum = {}; n_sent = 0;
        for (int c = 0; c < 18; c++) begin
            out_ready_r = !(c >= 3 && c <= 6);
            if (n_sent < 5) begin in_valid_r = 1'b1; partial_r = {$urandom, $urandom}; end
            else in_valid_r = 1'b0;
            if (c >= 4 && c <= 6) check_eq("t3_stall_in_ready", bus16.in_ready, 1'b0);
            if (bus16.out_valid && out_ready_r) got_sum.push_back(int'(bus16.sum));
            if (in_valid_r && (!mv[2] || out_ready_r)) begin
                exp_q.push_back(lane_total(partial_r)); n_sent++;
            end
            step();
        end
        out_ready_r = 1'b1;
        check_eq("t3_delivered", got_sum.size(), 5);
        if (got_sum.size() == 5 && exp_q.size() == 5)
            for (int i = 0; i < 5; i++) check_eq("t3_order", got_sum[i], exp_q[i]);
        check_eq("t3_cnt", cnt16, 16'd5);

        // Four deliveries of 60, then a clear that coincides with the fifth
        do_reset();
        send_and_drain(p_all10, 4);
        check_eq("t4_acc", acc16, 16'd240);
        check_eq("t4_cnt", cnt16, 16'd4);
        partial_r = p_all10; in_valid_r = 1'b1; step(); in_valid_r = 1'b0;
        guard = 0;
        while (!bus16.out_valid && guard < 10) begin step(); guard++; end
        check_eq("t4_wait_timeout", guard < 10, 1'b1);
        acc_clear_r = 1'b1; step(); acc_clear_r = 1'b0;
        check_eq("t4_clr_acc", acc16, 16'd0);
        check_eq("t4_clr_cnt", cnt16, 16'd0);
        check_eq("t4_clr_acc8", acc8, 8'd0);
        check_eq("t4_clr_out_valid", bus16.out_valid, 1'b0);

        // Saturation of the 8-bit accumulator: 250 + 60 -> 255
        do_reset();
        send_and_drain(p_all10, 4);
        send_and_drain(p_ten, 1);
        check_eq("t5_acc8_pre", acc8, 8'd250);
        send_and_drain(p_all10, 1);
        check_eq("t5_acc8_sat", acc8, 8'd255);
        check_eq("t5_acc16", acc16, 16'd310);
        check_eq("t5_cnt8", cnt8, 8'd6);

        // Reset with two beats in flight discards them
        partial_r = p_all10; in_valid_r = 1'b1; step(); step(); in_valid_r = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t6_no_out", bus16.out_valid, 1'b0);
        end
        check_eq("t6_acc", acc16, 16'd0);
        check_eq("t6_cnt", cnt16, 16'd0);
        check_eq("t6_in_ready", bus16.in_ready, 1'b1);

        // Random traffic, back-pressure, clears and occasional resets
        for (int c = 0; c < 600; c++) begin
            in_valid_r  = ($urandom_range(0, 99) < 70);
            out_ready_r = ($urandom_range(0, 99) < 65);
            acc_clear_r = ($urandom_range(0, 99) < 4);
            reset_r     = ($urandom_range(0, 199) == 0);
            partial_r   = {$urandom, $urandom};
            step();
        end
        reset_r = 1'b0; acc_clear_r = 1'b0; in_valid_r = 1'b0; out_ready_r = 1'b1;
        for (int i = 0; i < 5; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
